// File: rtl/spi_target_pkg.sv
// spi_target_pkg -- shared types and constants for the SPI target register block
// rev 1.0
`default_nettype none
`timescale 1ns/1ps

package spi_target_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int         CMD_RW_BIT      = 7;
  localparam logic [7:0] BLOCK_SEL       = 8'h04;
  localparam logic [7:0] DEFAULT_ID_BYTE = 8'h5A;

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// sync_edge_det -- multi-flop synchroniser with edge detection on the synchronised level
// rev 1.0
`default_nettype none
`timescale 1ns/1ps

module sync_edge_det #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Edges compare the fully synchronised sample with the one before it.
  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

`default_nettype wire

// File: rtl/spi_target_regs.sv
// spi_target_regs -- oversampled SPI mode-0 target sharing a byte register file with the CPU bus
// rev 1.0
`default_nettype none
`timescale 1ns/1ps

module spi_target_regs
  import spi_target_pkg::*;
#(
  parameter int         NUM_REGS    = 8,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_BYTE     = DEFAULT_ID_BYTE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  input  logic [3:0]  wstrb,
  input  logic        valid,
  output logic        ready,
  input  logic        spi_sck,
  input  logic        spi_csn,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        irq
);

  localparam int         AW         = $clog2(NUM_REGS);
  localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

  logic [7:0]    regs [NUM_REGS];

  logic          sck_level, sck_rise, sck_fall;
  logic          csn_level, csn_rise, csn_fall;
  logic          mosi_level, mosi_rise, mosi_fall;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx_sr;
  logic [7:0]    tx_sr;
  logic          rw;
  logic [6:0]    addr;

  logic [7:0]    rx_byte;
  logic          byte_done;
  logic          spi_commit;
  logic          cpu_accept;
  logic          cpu_wr;
  logic [AW-1:0] cpu_sel;
  logic          unused_bits;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clock (clock),
    .reset (reset),
    .din   (spi_sck),
    .level (sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  // csn idles high, so its synchroniser resets high to keep MISO tri-stated.
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_csn_sync (
    .clock (clock),
    .reset (reset),
    .din   (spi_csn),
    .level (csn_level),
    .rise  (csn_rise),
    .fall  (csn_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clock (clock),
    .reset (reset),
    .din   (spi_mosi),
    .level (mosi_level),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  assign spi_miso_oe = ~csn_level;

  function automatic logic in_range(input logic [6:0] a);
    return ({1'b0, a} < NUM_REGS_B);
  endfunction

  function automatic logic [7:0] spi_rd(input logic [6:0] a);
    return in_range(a) ? regs[a[AW-1:0]] : 8'h00;
  endfunction

  assign rx_byte    = {rx_sr[6:0], mosi_level};
  assign byte_done  = sck_rise && (bit_cnt == 3'd7);
  assign spi_commit = (state == DATA) && byte_done && !rw && in_range(addr) && !csn_rise;

  assign cpu_accept = valid && (address[23:16] == BLOCK_SEL) && !ready;
  assign cpu_wr     = cpu_accept && wstrb[0];
  assign cpu_sel    = address[2 +: AW];

  assign unused_bits = ^{address[15:2+AW], address[1:0], write_data[31:8], wstrb[3:1],
                         sck_level, mosi_rise, mosi_fall};

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      rx_sr    <= 8'h00;
      tx_sr    <= 8'h00;
      rw       <= 1'b0;
      addr     <= 7'd0;
      spi_miso <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq <= spi_commit;
      if (csn_rise) begin
        state    <= IDLE;
        bit_cnt  <= 3'd0;
        spi_miso <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (csn_fall) begin
              state    <= CMD;
              bit_cnt  <= 3'd0;
              tx_sr    <= ID_BYTE;
              spi_miso <= ID_BYTE[7];
            end
          end
          CMD, DATA: begin
            if (sck_rise) begin
              rx_sr   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (state == CMD) begin
                  state <= DATA;
                  rw    <= rx_byte[CMD_RW_BIT];
                  addr  <= rx_byte[6:0];
                  tx_sr <= rx_byte[CMD_RW_BIT] ? spi_rd(rx_byte[6:0]) : 8'h00;
                end else begin
                  addr  <= addr + 7'd1;
                  tx_sr <= rw ? spi_rd(addr + 7'd1) : 8'h00;
                end
              end
            end else if (sck_fall) begin
              // The fall before a byte's first rise presents the freshly loaded MSB.
              if (bit_cnt == 3'd0) begin
                spi_miso <= tx_sr[7];
              end else begin
                spi_miso <= tx_sr[6];
                tx_sr    <= {tx_sr[6:0], 1'b0};
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // CPU write is applied last so it wins a same-cycle collision with an SPI commit.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      if (spi_commit) begin
        regs[addr[AW-1:0]] <= rx_byte;
      end
      if (cpu_wr) begin
        regs[cpu_sel] <= write_data[7:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ready     <= 1'b0;
      read_data <= 32'h0;
    end else begin
      ready <= cpu_accept;
      if (cpu_accept) begin
        read_data <= {24'h0, regs[cpu_sel]};
      end
    end
  end

endmodule

`default_nettype wire
